// File: rtl/window_ring_buffer.sv
// ============================================================================
// Module  : window_ring_buffer
// Brief   : Circular FIFO with PAR_WRITE-wide pushes and a sliding PAR_READ window
//           that retires POP_STRIDE elements per pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module window_ring_buffer #(
   parameter  int SIZE        = 8,
   parameter  int MEM_SIZE    = 8,
   parameter  int PAR_WRITE   = 2,
   parameter  int PAR_READ    = 3,
   parameter  int POP_STRIDE  = 1,
   localparam int ADDRES_SIZE = $clog2(MEM_SIZE),
   localparam int CNT_SIZE    = $clog2(MEM_SIZE + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [PAR_WRITE*SIZE-1:0] din,
   input  logic                      din_valid,
   output logic                      din_ready,
   output logic [PAR_READ*SIZE-1:0]  dout,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [CNT_SIZE-1:0]       count
);

   // A depth of one still needs a one-bit pointer.
   localparam int PTR_W = (ADDRES_SIZE < 1) ? 1 : ADDRES_SIZE;

   localparam logic [PTR_W:0]      c_mem_size   = (PTR_W+1)'(MEM_SIZE);
   localparam logic [CNT_SIZE-1:0] c_room       = CNT_SIZE'(MEM_SIZE - PAR_WRITE);
   localparam logic [CNT_SIZE-1:0] c_par_read   = CNT_SIZE'(PAR_READ);
   localparam logic [CNT_SIZE-1:0] c_par_write  = CNT_SIZE'(PAR_WRITE);
   localparam logic [CNT_SIZE-1:0] c_pop_stride = CNT_SIZE'(POP_STRIDE);

   generate
      if (POP_STRIDE < 1 || POP_STRIDE > PAR_READ || PAR_WRITE < 1 || PAR_READ < 1 ||
          MEM_SIZE < PAR_WRITE || MEM_SIZE < PAR_READ) begin : g_param_check
         $error("window_ring_buffer: illegal parameter combination");
      end
   endgenerate

   // Offsets never exceed MEM_SIZE, so one conditional subtract wraps correctly
   // for any depth, power of two or not.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W:0]   off);
      logic [PTR_W:0] sum;
      sum = {1'b0, base} + off;
      if (sum >= c_mem_size) sum = sum - c_mem_size;
      return sum[PTR_W-1:0];
   endfunction

   logic [SIZE-1:0]     mem_q [MEM_SIZE];
   logic [PTR_W-1:0]    wptr_q, wptr_d;
   logic [PTR_W-1:0]    rptr_q, rptr_d;
   logic [CNT_SIZE-1:0] count_q, count_d;
   logic                w_push, w_pop;
   logic [PTR_W-1:0]    w_waddr [PAR_WRITE];

   assign din_ready  = (count_q <= c_room);
   assign dout_valid = (count_q >= c_par_read);
   assign count      = count_q;
   assign w_push     = din_valid & din_ready;
   assign w_pop      = dout_valid & dout_ready;

   generate
      for (genvar gi = 0; gi < PAR_WRITE; gi++) begin : g_wr_addr
         assign w_waddr[gi] = ptr_add(wptr_q, (PTR_W+1)'(gi));
      end
      for (genvar gi = 0; gi < PAR_READ; gi++) begin : g_rd_window
         assign dout[gi*SIZE +: SIZE] = mem_q[ptr_add(rptr_q, (PTR_W+1)'(gi))];
      end
   endgenerate

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (w_push) wptr_d = ptr_add(wptr_q, (PTR_W+1)'(PAR_WRITE));
         if (w_pop)  rptr_d = ptr_add(rptr_q, (PTR_W+1)'(POP_STRIDE));
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_par_write;
            2'b01:   count_d = count_q - c_pop_stride;
            2'b11:   count_d = count_q + c_par_write - c_pop_stride;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Flush wins over a coincident push, so nothing is written in that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
      end else if (w_push && !flush) begin
         for (int i = 0; i < PAR_WRITE; i++) mem_q[w_waddr[i]] <= din[i*SIZE +: SIZE];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_window_ring_buffer.sv
// ============================================================================
// Module  : tb_window_ring_buffer
// Brief   : Directed scoreboard bench for window_ring_buffer (stride 1 and stride 3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_ring_buffer;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_flush, a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
   logic [15:0] a_din;
   logic [23:0] a_dout;
   logic [3:0]  a_count;

   logic        b_flush, b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
   logic [15:0] b_din;
   logic [23:0] b_dout;
   logic [3:0]  b_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [23:0] a_q[$];
   logic [23:0] b_q[$];

   always #5 clk = ~clk;

   window_ring_buffer #(.SIZE(8), .MEM_SIZE(8), .PAR_WRITE(2), .PAR_READ(3), .POP_STRIDE(1)) dut_a (
      .clk(clk), .rst(rst), .flush(a_flush),
      .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
      .dout(a_dout), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
      .count(a_count)
   );

   window_ring_buffer #(.SIZE(8), .MEM_SIZE(8), .PAR_WRITE(2), .PAR_READ(3), .POP_STRIDE(3)) dut_b (
      .clk(clk), .rst(rst), .flush(b_flush),
      .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
      .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
      .count(b_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every pop handshake seen by a DUT consumes one expected window.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (a_dout_valid && a_dout_ready) begin
            if (a_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL A unexpected pop: got window 0x%0h, expected no pop", a_dout);
            end else check("A pop window", a_dout, a_q.pop_front());
         end
         if (b_dout_valid && b_dout_ready) begin
            if (b_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL B unexpected pop: got window 0x%0h, expected no pop", b_dout);
            end else check("B pop window", b_dout, b_q.pop_front());
         end
      end
   end

   task automatic a_step(input logic pv, input logic [15:0] d, input logic pr, input logic fl,
                         input bit exp_pop, input logic [23:0] exp_win);
      a_din_valid = pv; a_din = d; a_dout_ready = pr; a_flush = fl;
      if (exp_pop) a_q.push_back(exp_win);
      @(posedge clk); #1;
      a_din_valid = 1'b0; a_dout_ready = 1'b0; a_flush = 1'b0;
   endtask

   task automatic b_step(input logic pv, input logic [15:0] d, input logic pr, input logic fl,
                         input bit exp_pop, input logic [23:0] exp_win);
      b_din_valid = pv; b_din = d; b_dout_ready = pr; b_flush = fl;
      if (exp_pop) b_q.push_back(exp_win);
      @(posedge clk); #1;
      b_din_valid = 1'b0; b_dout_ready = 1'b0; b_flush = 1'b0;
   endtask

   task automatic a_status(input string tag, input int cnt, input logic dv, input logic dr,
                           input logic [23:0] win, input bit chk_win);
      check({tag, " A count"}, a_count, cnt);
      check({tag, " A dout_valid"}, a_dout_valid, dv);
      check({tag, " A din_ready"}, a_din_ready, dr);
      if (chk_win) check({tag, " A dout"}, a_dout, win);
   endtask

   task automatic b_status(input string tag, input int cnt, input logic dv, input logic dr,
                           input logic [23:0] win, input bit chk_win);
      check({tag, " B count"}, b_count, cnt);
      check({tag, " B dout_valid"}, b_dout_valid, dv);
      check({tag, " B din_ready"}, b_din_ready, dr);
      if (chk_win) check({tag, " B dout"}, b_dout, win);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      a_flush = 1'b0; a_din = 16'hAAAA; a_din_valid = 1'b1; a_dout_ready = 1'b0;
      b_flush = 1'b0; b_din = 16'h5555; b_din_valid = 1'b1; b_dout_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1; a_din_valid = 1'b0; b_din_valid = 1'b0;
      a_status("reset", 0, 1'b0, 1'b1, 24'h000000, 1'b1);
      b_status("reset", 0, 1'b0, 1'b1, 24'h000000, 1'b1);

      // Window fill and slide
      a_step(1'b1, 16'h0201, 1'b0, 1'b0, 1'b0, 24'h0);
      a_step(1'b1, 16'h0403, 1'b0, 1'b0, 1'b0, 24'h0);
      a_status("fill", 4, 1'b1, 1'b1, 24'h030201, 1'b1);
      a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 24'h030201);
      a_status("slide", 3, 1'b1, 1'b1, 24'h040302, 1'b1);
      a_step(1'b1, 16'h0605, 1'b1, 1'b0, 1'b1, 24'h040302);
      a_status("push+pop", 4, 1'b1, 1'b1, 24'h050403, 1'b1);

      // Asynchronous reset in the middle of a cycle, with a push pending
      a_din_valid = 1'b1; a_din = 16'h7777;
      #2 rst = 1'b0;
      #1;
      a_status("async rst", 0, 1'b0, 1'b1, 24'h000000, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; a_din_valid = 1'b0;
      a_status("after rst", 0, 1'b0, 1'b1, 24'h000000, 1'b1);

      // Pop at empty is blocked; only the push lands
      a_step(1'b1, 16'h0201, 1'b1, 1'b0, 1'b0, 24'h0);
      a_status("empty push+pop", 2, 1'b0, 1'b1, 24'h000000, 1'b0);
      a_step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 24'h0);
      a_status("flush", 0, 1'b0, 1'b1, 24'h000000, 1'b0);

      // Fill to full, then back-pressure
      a_step(1'b1, 16'h0201, 1'b0, 1'b0, 1'b0, 24'h0);
      a_step(1'b1, 16'h0403, 1'b0, 1'b0, 1'b0, 24'h0);
      a_step(1'b1, 16'h0605, 1'b0, 1'b0, 1'b0, 24'h0);
      a_step(1'b1, 16'h0807, 1'b0, 1'b0, 1'b0, 24'h0);
      a_status("full", 8, 1'b1, 1'b0, 24'h030201, 1'b1);
      a_step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 24'h0);
      a_status("blocked push", 8, 1'b1, 1'b0, 24'h030201, 1'b1);
      a_step(1'b1, 16'hEEEE, 1'b1, 1'b0, 1'b1, 24'h030201);
      a_status("full push+pop", 7, 1'b1, 1'b0, 24'h040302, 1'b1);

      // Wrap-around of both pointers
      a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 24'h040302);
      a_status("pop2", 6, 1'b1, 1'b1, 24'h050403, 1'b1);
      a_step(1'b1, 16'h0A09, 1'b0, 1'b0, 1'b0, 24'h0);
      a_status("wrap push", 8, 1'b1, 1'b0, 24'h050403, 1'b1);
      a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 24'h050403);
      a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 24'h060504);
      a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 24'h070605);
      a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 24'h080706);
      a_status("pop4", 4, 1'b1, 1'b1, 24'h090807, 1'b1);
      a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 24'h090807);
      a_status("wrap window", 3, 1'b1, 1'b1, 24'h0A0908, 1'b1);

      // Stride-3 instance and flush
      b_step(1'b1, 16'h0201, 1'b0, 1'b0, 1'b0, 24'h0);
      b_step(1'b1, 16'h0403, 1'b0, 1'b0, 1'b0, 24'h0);
      b_step(1'b1, 16'h0605, 1'b0, 1'b0, 1'b0, 24'h0);
      b_status("stride fill", 6, 1'b1, 1'b1, 24'h030201, 1'b1);
      b_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 24'h030201);
      b_status("stride pop", 3, 1'b1, 1'b1, 24'h060504, 1'b1);
      b_step(1'b1, 16'h0807, 1'b0, 1'b1, 1'b0, 24'h0);
      b_status("stride flush", 0, 1'b0, 1'b1, 24'h000000, 1'b0);
      b_step(1'b1, 16'h0A09, 1'b0, 1'b0, 1'b0, 24'h0);
      b_status("post flush", 2, 1'b0, 1'b1, 24'h030A09, 1'b1);

      repeat (2) @(posedge clk);
      #1;
      check("A scoreboard leftover", a_q.size(), 0);
      check("B scoreboard leftover", b_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/window_ring_buffer.md
Name: window_ring_buffer

Overview:
- Parametrised successor of the team's parallel-write/parallel-read element buffer, as a circular FIFO with valid/ready handshakes on both sides.
- Accepts PAR_WRITE elements per push.
- Presents the PAR_READ oldest elements as a read window.
- Each pop retires POP_STRIDE elements, so the window slides, e.g. a convolution input line buffer feeding a PE row.
- Tracks occupancy, asserts back-pressure and supports synchronous flush.

Parameters:
- SIZE, 8, bits per element.
- MEM_SIZE, 8, depth in elements; any integer >= max(PAR_WRITE, PAR_READ); need not be a power of two.
- PAR_WRITE, 2, elements written per push.
- PAR_READ, 3, elements visible in the read window.
- POP_STRIDE, 1, elements retired per pop; 1 <= POP_STRIDE <= PAR_READ.
- Derived: ADDRES_SIZE = $clog2(MEM_SIZE), CNT_SIZE = $clog2(MEM_SIZE+1).

Ports:
- clk, input, 1, clock; all state changes on rising edge.
- rst, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous clear of contents/occupancy.
- din, input, PAR_WRITE*SIZE, write elements; element 0 in bits [SIZE-1:0].
- din_valid, input, 1, push request.
- din_ready, output, 1, space for PAR_WRITE elements.
- dout, output, PAR_READ*SIZE, read window; element 0 (oldest) in bits [SIZE-1:0].
- dout_valid, output, 1, at least PAR_READ elements stored.
- dout_ready, input, 1, pop request.
- count, output, CNT_SIZE, current occupancy in elements.

Behaviour:
- State: mem[0..MEM_SIZE-1], wptr, rptr (ADDRES_SIZE bits), count register.
- Reset (rst=0, no clock needed): wptr=rptr=count=0; all mem entries 0. Resulting outputs: dout=0, dout_valid=0, din_ready=1.
- Reset may assert mid-operation; any in-flight push/pop is discarded.
- din_ready = (MEM_SIZE - count >= PAR_WRITE), decoded from registered count only; no same-cycle pass-through from pop.
- dout_valid = (count >= PAR_READ).
- Push fires on din_valid & din_ready:
  - element i is written to mem[(wptr+i) mod MEM_SIZE];
  - wptr advances by PAR_WRITE mod MEM_SIZE.
- Pop fires on dout_valid & dout_ready; rptr advances by POP_STRIDE mod MEM_SIZE.
- din_valid while din_ready=0 is ignored; no state change. Same for dout_ready while dout_valid=0.
- dout element i = mem[(rptr+i) mod MEM_SIZE], combinational from registers. Zero-latency window: valid in the cycle after the push that completed it.
- Contents below the window threshold remain visible on dout but are don't-care while dout_valid=0.
- Wrap-around: pointer sums use compare-and-subtract (sum >= MEM_SIZE -> sum - MEM_SIZE). Correct for non-power-of-two MEM_SIZE.
- count next value:
  - push only: count + PAR_WRITE.
  - pop only: count - POP_STRIDE.
  - both in the same cycle: count + PAR_WRITE - POP_STRIDE.
  - neither: unchanged.
- count never exceeds MEM_SIZE and never goes negative, guaranteed by the handshake gating.
- Simultaneous push+pop at full: push is blocked by din_ready=0; only the pop fires.
- Simultaneous push+pop at empty: pop is blocked; only the push fires.
- flush=1 at a clock edge: wptr=rptr=count=0. Dominates push and pop in that cycle. mem is not cleared.
- Overlap of retained elements: with POP_STRIDE < PAR_READ, PAR_READ - POP_STRIDE elements remain in the next window after each pop.
- Parameter violations (stride out of range, MEM_SIZE too small) stop elaboration via a generate-time check.

Test Plan:
- Reset: hold rst=0 with din_valid=1 for 3 clocks, release -> count=0, din_ready=1, dout_valid=0, dout=0x000000. Assert rst=0 mid-cycle -> outputs clear before the next edge.
- Window/slide (defaults): push din=0x0201, then push 0x0403 -> count=4, dout_valid=1, dout=0x030201. One pop -> dout=0x040302, count=3, dout_valid=1.
- Full/back-pressure: from empty push 0x0201, 0x0403, 0x0605, 0x0807 -> count=8, din_ready=0. A further push of 0xFFFF with din_valid=1 is ignored: count stays 8, data unchanged.
- Wrap-around: from the full state above, pop 2 -> count=6, din_ready=1. Push 0x0A09 (writes mem[0], mem[1]). Pop 4 -> rptr=6, dout=0x090807, count=4.
- Simultaneous push+pop:
  - at count=3 with dout_ready=1 and din_valid=1 -> count=4, window advances by 1;
  - at count=8 -> only pop, count=7.
- Flush and stride: instance with POP_STRIDE=3. Push 1..6, one pop -> dout=0x060504, count=3. Then flush=1 with din_valid=1 -> count=0, dout_valid=0, din_ready=1.
